obi_axi_bridge: RTL and testbench



---
 rtl/obi_axi_bridge.sv | 279 +++++++++++++++++++++++++++
 tb/tb_obi_axi_bridge.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_axi_bridge.sv
// OBI-to-AXI4 bridge: one core-side OBI port onto an AXI4 manager port.
// Single-beat transactions with a constant ID. Completions return to OBI
// in request order, and AXI SLVERR/DECERR come back as an OBI error.

package obi_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned USER_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic [USER_W-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

module obi_axi_bridge #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AXI_ID_WIDTH    = 2,
  parameter int unsigned AXI_ID          = 0,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter type axi_req_t = obi_axi_bridge_pkg::axi_req_t,
  parameter type axi_rsp_t = obi_axi_bridge_pkg::axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      rvalid_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      err_o,
  output axi_req_t                  axi_req_o,
  input  axi_rsp_t                  axi_rsp_i
);

  // Handshake semantics: on every AXI channel a transfer happens on the
  // rising edge where valid and ready are both high; valid never waits on
  // ready and, once raised, stays up with stable payload until that edge.
  // On OBI, a request transfers in the cycle where req_i and gnt_o are both
  // high; rvalid_o is a single-cycle pulse per completed transaction.

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]       AXI_SIZE = 3'($clog2(DATA_WIDTH / 8));

  // Channel slots
  logic                    ar_valid_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic                    aw_valid_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic                    w_valid_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;

  // Order FIFO: one bit per outstanding transaction, 1 = write
  logic [MAX_OUTSTANDING-1:0] order_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;

  // Registered completion
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic slot_free, fifo_full, fifo_empty, head_we;
  logic r_ready, b_ready, push, pop;

  // r.last, r.id, b.id, user fields and resp[0] carry no information here
  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.r.id, axi_rsp_i.r.last, axi_rsp_i.r.user,
                        axi_rsp_i.r.resp[0], axi_rsp_i.b.id, axi_rsp_i.b.user,
                        axi_rsp_i.b.resp[0]};

  // Grant, ordering and handshake decode
  always_comb begin
    ar_hs      = ar_valid_q & axi_rsp_i.ar_ready;
    aw_hs      = aw_valid_q & axi_rsp_i.aw_ready;
    w_hs       = w_valid_q & axi_rsp_i.w_ready;
    // A write needs both its slots; a slot draining this cycle counts as free.
    slot_free  = we_i ? ((~aw_valid_q | axi_rsp_i.aw_ready) & (~w_valid_q | axi_rsp_i.w_ready))
                      : (~ar_valid_q | axi_rsp_i.ar_ready);
    // A pop in the same cycle does not make room: full means no grant.
    fifo_full  = (count_q == CNT_MAX);
    fifo_empty = (count_q == '0);
    gnt_o      = req_i & ~fifo_full & slot_free;
    head_we    = order_q[rd_ptr_q];
    // Only the response type at the FIFO head is accepted; the other stalls.
    r_ready    = ~fifo_empty & ~head_we;
    b_ready    = ~fifo_empty & head_we;
    r_hs       = axi_rsp_i.r_valid & r_ready;
    b_hs       = axi_rsp_i.b_valid & b_ready;
    push       = gnt_o;
    pop        = r_hs | b_hs;
  end

  // AXI request channels: slot contents plus constant single-beat attributes
  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw_valid  = aw_valid_q;
    axi_req_o.aw.id     = AXI_ID_WIDTH'(AXI_ID);
    axi_req_o.aw.addr   = aw_addr_q;
    axi_req_o.aw.len    = 8'd0;
    axi_req_o.aw.size   = AXI_SIZE;
    axi_req_o.aw.burst  = 2'b01;
    axi_req_o.aw.cache  = 4'b0010;
    axi_req_o.w_valid   = w_valid_q;
    axi_req_o.w.data    = w_data_q;
    axi_req_o.w.strb    = w_strb_q;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.b_ready   = b_ready;
    axi_req_o.ar_valid  = ar_valid_q;
    axi_req_o.ar.id     = AXI_ID_WIDTH'(AXI_ID);
    axi_req_o.ar.addr   = ar_addr_q;
    axi_req_o.ar.len    = 8'd0;
    axi_req_o.ar.size   = AXI_SIZE;
    axi_req_o.ar.burst  = 2'b01;
    axi_req_o.ar.cache  = 4'b0010;
    axi_req_o.r_ready   = r_ready;
  end

  // Channel slots: load on grant, clear on their own handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      if (gnt_o && !we_i) begin
        ar_valid_q <= 1'b1;
        ar_addr_q  <= addr_i;
      end else if (ar_hs) begin
        ar_valid_q <= 1'b0;
      end
      if (gnt_o && we_i) begin
        aw_valid_q <= 1'b1;
        aw_addr_q  <= addr_i;
      end else if (aw_hs) begin
        aw_valid_q <= 1'b0;
      end
      if (gnt_o && we_i) begin
        w_valid_q <= 1'b1;
        w_data_q  <= wdata_i;
        w_strb_q  <= be_i;
      end else if (w_hs) begin
        w_valid_q <= 1'b0;
      end
    end
  end

  // Order FIFO: push the type on grant, pop on the head's response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      order_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        order_q[wr_ptr_q] <= we_i;
        wr_ptr_q          <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Completion register: one rvalid_o pulse the cycle after each R/B handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pop;
      if (r_hs) begin
        err_q   <= axi_rsp_i.r.resp[1];
        rdata_q <= axi_rsp_i.r.data;
      end else if (b_hs) begin
        err_q   <= axi_rsp_i.b.resp[1];
        rdata_q <= '0;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_obi_axi_bridge.sv
// Bench for obi_axi_bridge: randomised AXI slave, OBI driver tasks, an
// in-order completion scoreboard and directed scenario tasks.

module tb_obi_axi_bridge;
  import obi_axi_bridge_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    be = '0;
  logic [DW-1:0] wdata = '0;
  logic          gnt, rvalid, err;
  logic [DW-1:0] rdata;
  axi_req_t      axi_req;
  axi_rsp_t      axi_rsp;

  obi_axi_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ID_WIDTH(2), .AXI_ID(0),
    .MAX_OUTSTANDING(MAXO), .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .axi_req_o(axi_req), .axi_rsp_i(axi_rsp)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // ---------------- reference model ----------------
  logic [DW:0]      exp_q[$];     // {err, rdata} in grant order
  logic [AW-1:0]    exp_ar_q[$];
  logic [AW-1:0]    exp_aw_q[$];
  logic [DW+3:0]    exp_w_q[$];   // {strb, data}

  // Slave memory content: each address reads back a fixed pattern.
  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return a ^ 32'hDEAC_BEEF;
  endfunction

  // Region 0x4 is unmapped (DECERR), region 0x5 answers SLVERR.
  function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
    case (a[31:28])
      4'h4:    return 2'b11;
      4'h5:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic model_err(input logic [AW-1:0] a);
    return (a[31:28] == 4'h4) || (a[31:28] == 4'h5);
  endfunction

  function automatic bit roll(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  // ---------------- AXI slave ----------------
  int ar_pct = 100, aw_pct = 100, w_pct = 100, r_pct = 100, b_pct = 100;
  logic [DW+1:0]  r_pend_q[$];   // {resp, data}
  logic [1:0]     b_pend_q[$];
  logic [AW-1:0]  aw_acc_q[$];
  int             w_acc_cnt = 0;
  bit             r_done = 0, b_done = 0;
  int             first_r_hs_cyc = -1;
  int             last_rvalid_cyc = -1;

  initial begin
    axi_rsp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi_rsp = '0;
        r_done  = 0;
        b_done  = 0;
      end else begin
        axi_rsp.ar_ready = roll(ar_pct);
        axi_rsp.aw_ready = roll(aw_pct);
        axi_rsp.w_ready  = roll(w_pct);
        if (r_done) begin axi_rsp.r_valid = 1'b0; r_done = 0; end
        if (b_done) begin axi_rsp.b_valid = 1'b0; b_done = 0; end
        if (!axi_rsp.r_valid && r_pend_q.size() > 0 && roll(r_pct)) begin
          axi_rsp.r_valid = 1'b1;
          axi_rsp.r.data  = r_pend_q[0][DW-1:0];
          axi_rsp.r.resp  = r_pend_q[0][DW+1:DW];
          axi_rsp.r.last  = 1'b1;
        end
        if (!axi_rsp.b_valid && b_pend_q.size() > 0 && roll(b_pct)) begin
          axi_rsp.b_valid = 1'b1;
          axi_rsp.b.resp  = b_pend_q[0];
        end
        #4;
        if (rst_n) begin
          if (axi_req.ar_valid && axi_rsp.ar_ready) begin
            checks++;
            if (exp_ar_q.size() == 0) begin
              errors++; $display("FAIL ar_unexpected: addr %h, none required", axi_req.ar.addr);
            end else begin
              logic [AW-1:0] ea;
              ea = exp_ar_q.pop_front();
              if (axi_req.ar.addr !== ea || axi_req.ar.len !== 8'd0 || axi_req.ar.size !== 3'd2 ||
                  axi_req.ar.burst !== 2'b01 || axi_req.ar.cache !== 4'b0010 || axi_req.ar.id !== 2'd0) begin
                errors++;
                $display("FAIL ar_fields: addr %h len %0d size %0d burst %b cache %b id %0d, required addr %h len 0 size 2 burst 01 cache 0010 id 0",
                         axi_req.ar.addr, axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst,
                         axi_req.ar.cache, axi_req.ar.id, ea);
              end
            end
            r_pend_q.push_back({slave_resp(axi_req.ar.addr), slave_data(axi_req.ar.addr)});
          end
          if (axi_req.aw_valid && axi_rsp.aw_ready) begin
            checks++;
            if (exp_aw_q.size() == 0) begin
              errors++; $display("FAIL aw_unexpected: addr %h, none required", axi_req.aw.addr);
            end else begin
              logic [AW-1:0] ea;
              ea = exp_aw_q.pop_front();
              if (axi_req.aw.addr !== ea || axi_req.aw.len !== 8'd0 || axi_req.aw.size !== 3'd2 ||
                  axi_req.aw.burst !== 2'b01 || axi_req.aw.cache !== 4'b0010 || axi_req.aw.id !== 2'd0 ||
                  axi_req.aw.atop !== 6'd0) begin
                errors++;
                $display("FAIL aw_fields: addr %h len %0d size %0d burst %b cache %b id %0d, required addr %h len 0 size 2 burst 01 cache 0010 id 0",
                         axi_req.aw.addr, axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst,
                         axi_req.aw.cache, axi_req.aw.id, ea);
              end
            end
            aw_acc_q.push_back(axi_req.aw.addr);
          end
          if (axi_req.w_valid && axi_rsp.w_ready) begin
            checks++;
            if (exp_w_q.size() == 0) begin
              errors++; $display("FAIL w_unexpected: data %h, none required", axi_req.w.data);
            end else begin
              logic [DW+3:0] ew;
              ew = exp_w_q.pop_front();
              if ({axi_req.w.strb, axi_req.w.data} !== ew || axi_req.w.last !== 1'b1) begin
                errors++;
                $display("FAIL w_fields: strb %b data %h last %b, required strb %b data %h last 1",
                         axi_req.w.strb, axi_req.w.data, axi_req.w.last, ew[DW+3:DW], ew[DW-1:0]);
              end
            end
            w_acc_cnt++;
          end
          while (aw_acc_q.size() > 0 && w_acc_cnt > 0) begin
            b_pend_q.push_back(slave_resp(aw_acc_q.pop_front()));
            w_acc_cnt--;
          end
          if (axi_rsp.r_valid && axi_req.r_ready) begin
            void'(r_pend_q.pop_front());
            r_done = 1;
            if (first_r_hs_cyc < 0) first_r_hs_cyc = cyc;
          end
          if (axi_rsp.b_valid && axi_req.b_ready) begin
            void'(b_pend_q.pop_front());
            b_done = 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && rvalid) begin
        last_rvalid_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL completion_unexpected: err %b rdata %h, none required", err, rdata);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({err, rdata} !== e) begin
            errors++;
            $display("FAIL completion: err %b rdata %h, required err %b rdata %h", err, rdata, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic obi_req(input bit w, input logic [AW-1:0] a, input logic [3:0] b,
                         input logic [DW-1:0] d, input int budget, output int gcyc);
    bit done = 0;
    gcyc = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      #3;
      if (gnt === 1'b1) begin
        done = 1;
        gcyc = cyc;
        if (w) begin
          exp_q.push_back({model_err(a), {DW{1'b0}}});
          exp_aw_q.push_back(a);
          exp_w_q.push_back({b, d});
        end else begin
          exp_q.push_back({model_err(a), slave_data(a)});
          exp_ar_q.push_back(a);
        end
      end
    end
    if (done) begin
      @(posedge clk);
      #1 req = 1'b0;
    end else begin
      req = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL obi_grant: no grant for %s %h within %0d cycles, grant required", w ? "write" : "read", a, budget);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: %0d completions outstanding, 0 required", exp_q.size());
    end
  endtask

  task automatic set_pct(input int a, input int aw, input int w, input int r, input int b);
    ar_pct = a; aw_pct = aw; w_pct = w; r_pct = r; b_pct = b;
  endtask

  function automatic logic [AW-1:0] rand_addr(input logic [3:0] region);
    return {region, 28'($urandom) & 28'hFFF_FFFC};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: %b, required 0", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: %h, required 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: %b, required 0", err); end
    checks++;
    if ({axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_axi_valid: ar %b aw %b w %b, required 000", axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int g;
    set_pct(100, 100, 100, 100, 100);
    obi_req(0, 32'h0001_0000, 4'hF, '0, 5, g);
    drain(20);
    checks++;
    if (last_rvalid_cyc - g != 3) begin
      errors++; $display("FAIL read_latency: %0d cycles, required 3", last_rvalid_cyc - g);
    end
  endtask

  task automatic test_write_split();
    int g;
    logic [DW-1:0] wd2;
    wd2 = $urandom;
    set_pct(100, 100, 0, 100, 100);
    obi_req(1, 32'h8000_0004, 4'b0011, 32'h1234_5678, 5, g);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h8000_0008; be = 4'hF; wdata = wd2;
      #3;
      checks++;
      if (gnt !== 1'b0) begin errors++; $display("FAIL write_blocked: gnt %b cycle %0d, required 0", gnt, i); end
      if (i == 2) begin
        checks++;
        if (axi_req.aw_valid !== 1'b0 || axi_req.w_valid !== 1'b1) begin
          errors++; $display("FAIL split_slots: aw_valid %b w_valid %b, required 0 1", axi_req.aw_valid, axi_req.w_valid);
        end
      end
      if (i == 3) w_pct = 100;
    end
    obi_req(1, 32'h8000_0008, 4'hF, wd2, 1, g);
    drain(30);
  endtask

  task automatic test_max_outstanding();
    int g;
    logic [AW-1:0] a5;
    set_pct(100, 100, 100, 0, 100);
    for (int i = 0; i < MAXO; i++) obi_req(0, rand_addr(4'h1), 4'hF, '0, 1, g);
    a5 = rand_addr(4'h2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = a5; be = 4'hF;
      #3;
      checks++;
      if (gnt !== 1'b0) begin errors++; $display("FAIL full_block: gnt %b cycle %0d, required 0", gnt, i); end
    end
    first_r_hs_cyc = -1;
    r_pct = 100;
    obi_req(0, a5, 4'hF, '0, 10, g);
    checks++;
    if (g != first_r_hs_cyc + 1) begin
      errors++; $display("FAIL full_release: grant cycle %0d, required %0d", g, first_r_hs_cyc + 1);
    end
    drain(40);
  endtask

  task automatic test_write_then_read();
    int g;
    set_pct(100, 100, 100, 100, 0);
    obi_req(1, rand_addr(4'h3), 4'hF, $urandom, 1, g);
    obi_req(0, rand_addr(4'h3), 4'hF, '0, 1, g);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      checks++;
      if (axi_req.r_ready !== 1'b0) begin errors++; $display("FAIL r_stall: r_ready %b, required 0", axi_req.r_ready); end
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL early_completion: rvalid %b, required 0", rvalid); end
    end
    b_pct = 100;
    drain(30);
  endtask

  task automatic test_errors();
    int g;
    set_pct(100, 100, 100, 100, 100);
    obi_req(0, 32'h4000_0000, 4'hF, '0, 5, g);
    obi_req(1, 32'h5000_0010, 4'hF, $urandom, 5, g);
    obi_req(0, 32'h5000_0020, 4'hF, '0, 5, g);
    drain(30);
  endtask

  task automatic test_back_to_back();
    int g, prev;
    set_pct(100, 100, 100, 100, 100);
    for (int t = 0; t < 2; t++) begin
      prev = -1;
      for (int i = 0; i < 8; i++) begin
        obi_req(t[0], rand_addr(4'h6), 4'($urandom_range(1, 15)), $urandom, 2, g);
        if (i > 0) begin
          checks++;
          if (g != prev + 1) begin errors++; $display("FAIL back_to_back: grant gap %0d, required 1", g - prev); end
        end
        prev = g;
      end
    end
    drain(30);
  endtask

  task automatic test_random();
    int g;
    logic [3:0] regions [5];
    regions = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h8};
    for (int i = 0; i < 150; i++) begin
      if (i % 30 == 0)
        set_pct($urandom_range(20, 100), $urandom_range(20, 100), $urandom_range(20, 100),
                $urandom_range(20, 100), $urandom_range(20, 100));
      obi_req($urandom_range(0, 1), rand_addr(regions[$urandom_range(0, 4)]),
              4'($urandom_range(1, 15)), $urandom, 300, g);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain(2000);
  endtask

  task automatic test_reset_mid();
    int g;
    set_pct(100, 100, 100, 0, 100);
    obi_req(0, rand_addr(4'h1), 4'hF, '0, 2, g);
    obi_req(0, rand_addr(4'h1), 4'hF, '0, 2, g);
    ar_pct = 0;
    @(negedge clk);
    #1;
    checks++;
    if (axi_req.ar_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_ar: ar_valid %b, required 1", axi_req.ar_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, err, axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: rvalid %b err %b ar %b aw %b w %b r_ready %b b_ready %b, required all 0",
               rvalid, err, axi_req.ar_valid, axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready);
    end
    exp_q.delete(); exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    r_pend_q.delete(); b_pend_q.delete(); aw_acc_q.delete(); w_acc_cnt = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    set_pct(100, 100, 100, 0, 100);
    for (int i = 0; i < MAXO; i++) obi_req(0, rand_addr(4'h2), 4'hF, '0, 2, g);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h2000_0100; be = 4'hF;
    #3;
    checks++;
    if (gnt !== 1'b0) begin errors++; $display("FAIL post_reset_full: gnt %b, required 0", gnt); end
    r_pct = 100;
    obi_req(0, 32'h2000_0100, 4'hF, '0, 10, g);
    drain(40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_split();
    test_max_outstanding();
    test_write_then_read();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
